// File: rtl/pixel_copy_engine_pkg.sv
// Shared constants, encodings and address helper for the pixel copy engine.
// Screen geometry, tile size, colour key and source-memory select codes live here.
package pixel_copy_engine_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int TILE     = 10;
    localparam int ADDR_W   = 15;

    localparam logic [2:0] KEY_COLOUR = 3'b101;

    localparam logic [1:0] MEM_TITLE   = 2'd0;
    localparam logic [1:0] MEM_STAGE   = 2'd1;
    localparam logic [1:0] MEM_WIN     = 2'd2;
    localparam logic [1:0] MEM_SPRITES = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_FULL,
        OP_TILE,
        OP_PRINT
    } op_t;

    // y*160 + x built from constant shifts; 17-bit intermediate so nothing wraps early.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [8:0] x, input logic [7:0] y);
        logic [16:0] a;
        a = ({9'd0, y} << 7) + ({9'd0, y} << 5) + {8'd0, x};
        return a[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/pixel_copy_engine_raster_counter.sv
// Raster-order x/y counter with run-time width and height.
// x advances fastest; last flags the final (width-1, height-1) position.
module raster_counter (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear_i,
    input  logic       en_i,
    input  logic [7:0] width_i,
    input  logic [6:0] height_i,
    output logic [7:0] x_o,
    output logic [6:0] y_o,
    output logic       last_o
);

    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic       x_end, y_end;

    assign x_end  = (x_q == width_i - 8'd1);
    assign y_end  = (y_q == height_i - 7'd1);
    assign last_o = x_end && y_end;
    assign x_o    = x_q;
    assign y_o    = y_q;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear_i) begin
            x_d = '0;
            y_d = '0;
        end else if (en_i) begin
            if (x_end) begin
                x_d = '0;
                y_d = y_end ? 7'd0 : y_q + 7'd1;
            end else begin
                x_d = x_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/pixel_copy_engine.sv
// Copies full images or colour-keyed tiles into the frame buffer, or streams the
// frame buffer to the VGA adapter, one pixel per cycle with a 1-cycle read pipeline.
module pixel_copy_engine
    import pixel_copy_engine_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              copy_enable,
    input  logic              print_screen,
    input  logic              full_frame,
    input  logic [1:0]        memory_select,
    input  logic [7:0]        src_x,
    input  logic [6:0]        src_y,
    input  logic [7:0]        dst_x,
    input  logic [6:0]        dst_y,
    output logic [1:0]        src_sel,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [2:0]        src_data,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [2:0]        buf_wdata,
    output logic              buf_we,
    input  logic [2:0]        buf_rdata,
    output logic [7:0]        vga_x,
    output logic [6:0]        vga_y,
    output logic [2:0]        vga_colour,
    output logic              vga_plot,
    output logic              finished,
    output logic              busy
);

    state_t            state_q;
    op_t               op_q;
    logic [1:0]        sel_q;
    logic [7:0]        sx_q, dx_q;
    logic [6:0]        sy_q, dy_q;
    logic              finished_q, busy_q;

    // Write-side pipeline stage, aligned with the data returning from the read.
    logic              wr_valid_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              wr_clip_q;
    logic [7:0]        wr_x_q;
    logic [6:0]        wr_y_q;

    logic [7:0]        cnt_x;
    logic [6:0]        cnt_y;
    logic              cnt_last;
    logic [7:0]        width;
    logic [6:0]        height;
    logic              run;
    logic [8:0]        src_xs, dst_xs;
    logic [7:0]        src_ys, dst_ys;
    logic [ADDR_W-1:0] rd_src, rd_dst;
    logic              clip;
    logic              copy_write;
    logic              is_print;

    assign run      = (state_q == ST_RUN);
    assign is_print = (op_q == OP_PRINT);
    assign width    = (op_q == OP_TILE) ? 8'(TILE) : 8'(SCREEN_W);
    assign height   = (op_q == OP_TILE) ? 7'(TILE) : 7'(SCREEN_H);

    raster_counter u_raster (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (state_q == ST_IDLE),
        .en_i     (run),
        .width_i  (width),
        .height_i (height),
        .x_o      (cnt_x),
        .y_o      (cnt_y),
        .last_o   (cnt_last)
    );

    // Widened sums: a tile hanging off the right/bottom edge must clip, not wrap.
    assign src_xs = {1'b0, sx_q} + {1'b0, cnt_x};
    assign src_ys = {1'b0, sy_q} + {1'b0, cnt_y};
    assign dst_xs = {1'b0, dx_q} + {1'b0, cnt_x};
    assign dst_ys = {1'b0, dy_q} + {1'b0, cnt_y};
    assign rd_src = pix_addr(src_xs, src_ys);
    assign rd_dst = pix_addr(dst_xs, dst_ys);
    assign clip   = (dst_xs >= 9'(SCREEN_W)) || (dst_ys >= 8'(SCREEN_H));

    assign copy_write = wr_valid_q && !is_print && !wr_clip_q &&
                        !((op_q == OP_TILE) && (src_data == KEY_COLOUR));

    assign src_sel    = sel_q;
    assign src_addr   = (run && !is_print) ? rd_src : '0;
    assign buf_we     = copy_write;
    assign buf_wdata  = copy_write ? src_data : 3'd0;
    assign buf_addr   = is_print ? (run ? rd_dst : '0) : (wr_valid_q ? wr_addr_q : '0);
    assign vga_plot   = wr_valid_q && is_print;
    assign vga_x      = vga_plot ? wr_x_q : 8'd0;
    assign vga_y      = vga_plot ? wr_y_q : 7'd0;
    assign vga_colour = vga_plot ? buf_rdata : 3'd0;
    assign finished   = finished_q;
    assign busy       = busy_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_FULL;
            sel_q      <= '0;
            sx_q       <= '0;
            sy_q       <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            finished_q <= 1'b0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_clip_q  <= 1'b0;
            wr_x_q     <= '0;
            wr_y_q     <= '0;
        end else begin
            finished_q <= 1'b0;
            wr_valid_q <= run;
            wr_addr_q  <= rd_dst;
            wr_clip_q  <= clip;
            wr_x_q     <= dst_xs[7:0];
            wr_y_q     <= dst_ys[6:0];
            case (state_q)
                ST_IDLE: begin
                    if (copy_enable) begin
                        op_q    <= full_frame ? OP_FULL : OP_TILE;
                        sel_q   <= memory_select;
                        sx_q    <= full_frame ? 8'd0 : src_x;
                        sy_q    <= full_frame ? 7'd0 : src_y;
                        dx_q    <= full_frame ? 8'd0 : dst_x;
                        dy_q    <= full_frame ? 7'd0 : dst_y;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else if (print_screen) begin
                        op_q    <= OP_PRINT;
                        sel_q   <= memory_select;
                        sx_q    <= '0;
                        sy_q    <= '0;
                        dx_q    <= '0;
                        dy_q    <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cnt_last) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    finished_q <= 1'b1;
                    state_q    <= ST_DONE;
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_copy_engine.sv
// Directed bench for pixel_copy_engine: table of operations checked cycle by cycle
// against a behavioural expectation, plus back-to-back and mid-operation reset sequences.
module tb_pixel_copy_engine;
    import pixel_copy_engine_pkg::*;

    logic              clock = 1'b0;
    logic              reset;
    logic              copy_enable, print_screen, full_frame;
    logic [1:0]        memory_select;
    logic [7:0]        src_x, dst_x;
    logic [6:0]        src_y, dst_y;
    logic [1:0]        src_sel;
    logic [ADDR_W-1:0] src_addr, buf_addr;
    logic [2:0]        src_data, buf_wdata, buf_rdata, vga_colour;
    logic              buf_we, vga_plot, finished, busy;
    logic [7:0]        vga_x;
    logic [6:0]        vga_y;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    pixel_copy_engine dut (
        .clock         (clock),
        .reset         (reset),
        .copy_enable   (copy_enable),
        .print_screen  (print_screen),
        .full_frame    (full_frame),
        .memory_select (memory_select),
        .src_x         (src_x),
        .src_y         (src_y),
        .dst_x         (dst_x),
        .dst_y         (dst_y),
        .src_sel       (src_sel),
        .src_addr      (src_addr),
        .src_data      (src_data),
        .buf_addr      (buf_addr),
        .buf_wdata     (buf_wdata),
        .buf_we        (buf_we),
        .buf_rdata     (buf_rdata),
        .vga_x         (vga_x),
        .vga_y         (vga_y),
        .vga_colour    (vga_colour),
        .vga_plot      (vga_plot),
        .finished      (finished),
        .busy          (busy)
    );

    // Source ROM contents: 0 = index mod 8, 1 = flat 3'b010, 2 = key/001 checkerboard.
    function automatic logic [2:0] rom_fn(input int mode, input int addr);
        int x, y;
        x = addr % 160;
        y = addr / 160;
        if (mode == 0) return 3'(addr % 8);
        if (mode == 1) return 3'b010;
        return ((x + y) % 2 == 1) ? KEY_COLOUR : 3'b001;
    endfunction

    function automatic logic [2:0] fb_pat(input int a);
        return 3'((a * 3 + a / 160) % 8);
    endfunction

    logic [2:0] fb [0:32767];
    int         rom_mode = 0;
    logic       preload_fb = 1'b0;

    always @(posedge clock) begin
        src_data <= rom_fn(rom_mode, int'(src_addr));
        if (preload_fb) begin
            for (int a = 0; a < 19200; a++) fb[a] <= fb_pat(a);
        end else if (buf_we) begin
            fb[buf_addr] <= buf_wdata;
        end
        buf_rdata <= fb[buf_addr];
    end

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint all_outputs();
        return longint'({src_sel, src_addr, buf_addr, buf_wdata, buf_we, vga_x, vga_y,
                         vga_colour, vga_plot, finished, busy});
    endfunction

    typedef struct {
        bit         ce;
        bit         pe;
        bit         full;
        logic [1:0] sel;
        int         sx, sy, dx, dy;
        int         mode;
        int         n;
        int         exp_writes;
        int         exp_plots;
    } vec_t;

    vec_t vecs[5];

    task automatic run_op(input vec_t v, input int tag);
        int  n_fin, c_fin, n_we, n_plot, errs, first_we, sel_seen, w;
        bit  is_print, is_tile;
        string msg;
        n_fin = 0; c_fin = -1; n_we = 0; n_plot = 0; errs = 0; first_we = -1; sel_seen = -1;
        msg = "";
        is_print = !v.ce && v.pe;
        is_tile  = v.ce && !v.full;
        w = is_tile ? TILE : SCREEN_W;
        if (is_print) begin
            @(negedge clock); preload_fb = 1'b1;
            @(negedge clock); preload_fb = 1'b0;
        end
        rom_mode = v.mode;
        @(negedge clock);
        copy_enable = v.ce; print_screen = v.pe; full_frame = v.full;
        memory_select = v.sel;
        src_x = 8'(v.sx); src_y = 7'(v.sy); dst_x = 8'(v.dx); dst_y = 7'(v.dy);
        @(posedge clock);
        #1;
        copy_enable = 1'b0; print_screen = 1'b0;
        for (int c = 1; c <= v.n + 6; c++) begin
            int k, i, j, dxx, dyy, ea, ex, ey;
            bit exp_we, exp_plot;
            logic [2:0] ecol;
            @(negedge clock);
            k = c - 2; exp_we = 0; exp_plot = 0; ea = 0; ex = 0; ey = 0; ecol = 3'd0;
            if (k >= 0 && k < v.n) begin
                i = k % w;
                j = k / w;
                if (is_print) begin
                    exp_plot = 1; ex = i; ey = j; ecol = fb_pat(j * 160 + i);
                end else begin
                    dxx  = is_tile ? v.dx + i : i;
                    dyy  = is_tile ? v.dy + j : j;
                    ecol = rom_fn(v.mode, is_tile ? (v.sy + j) * 160 + v.sx + i : k);
                    exp_we = (dxx < SCREEN_W) && (dyy < SCREEN_H) &&
                             !(is_tile && ecol == KEY_COLOUR);
                    ea = dyy * 160 + dxx;
                end
            end
            if (c == 1) sel_seen = int'(src_sel);
            if ((buf_we !== exp_we) || (exp_we && (int'(buf_addr) != ea || buf_wdata != ecol)) ||
                (vga_plot !== exp_plot) ||
                (exp_plot && (int'(vga_x) != ex || int'(vga_y) != ey || vga_colour != ecol)) ||
                (busy !== (c <= v.n + 2))) begin
                if (errs == 0)
                    msg = $sformatf("cycle %0d we=%0b addr=%0d wd=%0d plot=%0b x=%0d y=%0d col=%0d busy=%0b, wanted we=%0b addr=%0d col=%0d plot=%0b x=%0d y=%0d",
                                    c, buf_we, buf_addr, buf_wdata, vga_plot, vga_x, vga_y,
                                    vga_colour, busy, exp_we, ea, ecol, exp_plot, ex, ey);
                errs++;
            end
            if (buf_we) begin
                n_we++;
                if (first_we < 0) first_we = c;
            end
            if (vga_plot) n_plot++;
            if (finished) begin
                n_fin++;
                c_fin = c;
            end
        end
        tests++;
        if (errs != 0) begin
            fails++;
            $display("FAIL op%0d_pixels: %0d bad cycles, first %s", tag, errs, msg);
        end
        check($sformatf("op%0d_writes", tag), n_we, v.exp_writes);
        check($sformatf("op%0d_plots", tag), n_plot, v.exp_plots);
        check($sformatf("op%0d_finished_count", tag), n_fin, 1);
        check($sformatf("op%0d_finished_cycle", tag), c_fin, v.n + 2);
        check($sformatf("op%0d_src_sel", tag), sel_seen, int'(v.sel));
        if (v.exp_writes > 0) check($sformatf("op%0d_first_write", tag), first_we, 2);
        $display("[TB] op %0d: writes=%0d plots=%0d finished at S+%0d", tag, n_we, n_plot, c_fin);
    endtask

    initial begin
        int fin_a, fin_b, n_fin, busy103, first2, nf;

        //          ce pe full sel    sx  sy  dx   dy   mode n      writes plots
        vecs[0] = '{1, 0, 1, 2'd1,   0,  0,  0,   0,   0, 19200, 19200, 0};
        vecs[1] = '{1, 0, 0, 2'd3,  20, 30, 50,  40,   1,   100,   100, 0};
        vecs[2] = '{1, 0, 0, 2'd3,   0,  0, 155, 115,  2,   100,    13, 0};
        vecs[3] = '{0, 1, 0, 2'd2,   0,  0,  0,   0,   0, 19200,     0, 19200};
        vecs[4] = '{1, 1, 0, 2'd0,  20, 30,  0,   0,   1,   100,   100, 0};

        reset = 1'b1;
        copy_enable = 0; print_screen = 0; full_frame = 0; memory_select = 0;
        src_x = 0; src_y = 0; dst_x = 0; dst_y = 0;
        repeat (3) @(negedge clock);
        check("reset_outputs", all_outputs(), 0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_outputs", all_outputs(), 0);

        for (int t = 0; t < 5; t++) run_op(vecs[t], t);

        // Back-to-back: copy_enable held across DONE starts a second tile copy at once.
        @(negedge clock);
        rom_mode = 1;
        copy_enable = 1; full_frame = 0; memory_select = 2'd3;
        src_x = 0; src_y = 0; dst_x = 10; dst_y = 10;
        @(posedge clock);
        fin_a = -1; fin_b = -1; n_fin = 0; busy103 = -1; first2 = -1;
        for (int c = 1; c <= 220; c++) begin
            @(negedge clock);
            if (finished) begin
                n_fin++;
                if (fin_a < 0) fin_a = c; else fin_b = c;
            end
            if (c == 103) busy103 = int'(busy);
            if (c > 103 && buf_we && first2 < 0) first2 = c;
            if (c == 150) copy_enable = 0;
        end
        check("b2b_finished_count", n_fin, 2);
        check("b2b_first_finished", fin_a, 102);
        check("b2b_second_finished", fin_b, 205);
        check("b2b_busy_between", busy103, 0);
        check("b2b_second_first_write", first2, 105);
        $display("[TB] back-to-back: finished at S+%0d and S+%0d", fin_a, fin_b);

        // Reset while pixel 50 of a tile copy is being written.
        @(negedge clock);
        copy_enable = 1; full_frame = 0; memory_select = 2'd1;
        src_x = 20; src_y = 30; dst_x = 50; dst_y = 40;
        @(posedge clock);
        #1;
        copy_enable = 0;
        repeat (52) @(negedge clock);
        check("reset_mid_busy_before", int'(busy), 1);
        reset = 1'b1;
        #1;
        check("reset_mid_async_outputs", all_outputs(), 0);
        @(posedge clock);
        #1;
        check("reset_mid_edge_outputs", all_outputs(), 0);
        @(negedge clock);
        reset = 1'b0;
        nf = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clock);
            if (finished) nf++;
        end
        check("reset_mid_no_finished", nf, 0);
        $display("[TB] reset mid-tile: finished pulses after reset=%0d", nf);
        run_op(vecs[1], 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
